// File: rtl/frame_streamer_if.sv
// pixel_valid_if: one pixel word plus its valid flag, moving from a pixel
// source to a pixel sink. The source uses the master modport.
//   pixel : PIXEL_W bits, {red, green, blue}, 8 bits each by default
//   valid : high in every cycle that pixel carries a frame pixel
interface pixel_valid_if #(
  parameter int PIXEL_W = 24
);
  logic [PIXEL_W-1:0] pixel;
  logic               valid;

  modport master (output pixel, output valid);
  modport slave  (input  pixel, input  valid);
endinterface

// File: rtl/frame_streamer.sv
// frame_streamer: reads one frame from a frame memory in raster order and
// sends it out as a pixel stream. After each line it can insert a fixed
// number of idle cycles.
//
// Ports
//   clk              : clock
//   rst              : synchronous, active-high reset
//   start_i          : one-cycle frame start request, seen only when idle
//   pause_i          : level; while it is high no new memory reads are issued
//   mem_en_o         : frame-memory read enable
//   mem_addr_o       : frame-memory read address, y*IMAGE_LEN + x
//   mem_data_i       : read data, valid one cycle after mem_en_o
//   pixel_valid_if_o : output pixel stream (pixel = mem_data_i, registered valid)
//   busy_o           : high from an accepted start until done_o has been shown
//   done_o           : one-cycle frame-complete pulse
module frame_streamer #(
  parameter int IMAGE_LEN    = 1080,
  parameter int IMAGE_HEIGHT = 720,
  parameter int LINE_GAP     = 2,
  parameter int PIXEL_W      = 24
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start_i,
  input  logic                                        pause_i,
  output logic                                        mem_en_o,
  output logic [$clog2(IMAGE_LEN*IMAGE_HEIGHT)-1:0]   mem_addr_o,
  input  logic [PIXEL_W-1:0]                          mem_data_i,
  pixel_valid_if.master                               pixel_valid_if_o,
  output logic                                        busy_o,
  output logic                                        done_o
);

  localparam int NPIX = IMAGE_LEN * IMAGE_HEIGHT;
  localparam int AW   = $clog2(NPIX);
  localparam int XW   = (IMAGE_LEN    > 1) ? $clog2(IMAGE_LEN)    : 1;
  localparam int YW   = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int GW   = (LINE_GAP     > 1) ? $clog2(LINE_GAP)     : 1;

  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_LEN - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);
  // GAP can only be entered when LINE_GAP > 0, so the 0 fallback is never used.
  localparam logic [GW-1:0] G_LAST = GW'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_GAP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  // Running raster address. It always equals y_q*IMAGE_LEN + x_q, so no
  // multiplier is needed.
  logic [AW-1:0]   addr_q, addr_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            vld_p1_q, vld_p1_d;

  // State register. Everything here is control, so all of it is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      addr_q   <= '0;
      gap_q    <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      addr_q   <= addr_d;
      gap_q    <= gap_d;
      vld_p1_q <= vld_p1_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    gap_d   = gap_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_STREAM;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          gap_d   = '0;
        end
      end

      S_STREAM: begin
        // A paused cycle issues no read, so every counter holds its value.
        if (!pause_i) begin
          addr_d = addr_q + 1'b1;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              state_d = S_DRAIN;
            end else begin
              y_d = y_q + 1'b1;
              if (LINE_GAP > 0) begin
                state_d = S_GAP;
                gap_d   = '0;
              end
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end

      S_GAP: begin
        // pause_i is ignored here, so the gap always lasts exactly LINE_GAP cycles.
        if (gap_q == G_LAST) begin
          state_d = S_STREAM;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      // The last read's data comes back during DRAIN.
      S_DRAIN: state_d = S_DONE;

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs. The address is held at zero outside STREAM.
  always_comb begin
    mem_en_o   = 1'b0;
    mem_addr_o = '0;
    busy_o     = 1'b1;
    done_o     = 1'b0;

    case (state_q)
      S_IDLE:   busy_o = 1'b0;
      S_STREAM: begin
        mem_en_o   = !pause_i;
        mem_addr_o = addr_q;
      end
      S_DONE:   done_o = 1'b1;
      default:  ;
    endcase
  end

  // Stage p0 -> p1: the read enable becomes valid in the cycle its data returns.
  assign vld_p1_d = mem_en_o;

  assign pixel_valid_if_o.valid = vld_p1_q;
  assign pixel_valid_if_o.pixel = mem_data_i;

endmodule
